// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: synchronises and debounces one-hot key lines, encodes them,
// and hands one code per physical press to the time-entry logic over valid/ready.
module keypad_debounce_encoder #(
    parameter int N_KEYS          = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit STRICT          = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keypad,
    input  logic              lock,
    input  logic              key_ready,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              multi_key,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CODE_W-1:0] stored, stored_n;
    logic [CODE_W-1:0] cand_code;
    logic [N_KEYS-1:0] sync1, sync2;
    logic              any_line, multi, cand_valid, emit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            multi_key <= 1'b0;
        end else begin
            sync1     <= keypad;
            sync2     <= sync1;
            multi_key <= multi;
        end
    end

    // Ascending scan: the last active line seen (highest index) wins.
    always_comb begin
        cand_code = '0;
        multi     = 1'b0;
        any_line  = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (sync2[i]) begin
                if (any_line) multi = 1'b1;
                any_line  = 1'b1;
                cand_code = (i == 0) ? '0 : CODE_W'(N_KEYS - i);
            end
        end
        cand_valid = any_line && !(STRICT && multi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            stored <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            stored <= stored_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stored_n = stored;
        if (lock) begin
            state_n = RELEASE_DB;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        state_n  = PRESS_DB;
                        stored_n = cand_code;
                        cnt_n    = CNT_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (!cand_valid) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cand_code != stored) begin
                        stored_n = cand_code;
                        cnt_n    = CNT_W'(1);
                    end else if (cnt >= CNT_LAST) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!any_line) begin
                        state_n = RELEASE_DB;
                        cnt_n   = CNT_W'(1);
                    end
                end
                RELEASE_DB: begin
                    if (any_line) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt >= CNT_LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        emit = !lock && (state == PRESS_DB) && cand_valid &&
               (cand_code == stored) && (cnt >= CNT_LAST);
    end

    // A handshake on the same edge frees the slot, so the new event is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else if (lock) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (key_valid && key_ready) key_valid <= 1'b0;
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= stored;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Scoreboard bench: two instances (strict and priority) share stimulus;
// expected codes are queued per instance and popped by a handshake monitor.
module tb_keypad_debounce_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] keypad = '0;
    logic       lock = 1'b0;
    logic       key_ready = 1'b1;

    logic       valid_a, multi_a, ovr_a;
    logic [3:0] code_a;
    logic       valid_b, multi_b, ovr_b;
    logic [3:0] code_b;

    int total = 0;
    int bad   = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    keypad_debounce_encoder #(.N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(16), .STRICT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .keypad(keypad), .lock(lock), .key_ready(key_ready),
        .key_valid(valid_a), .key_code(code_a), .multi_key(multi_a), .overrun(ovr_a)
    );

    keypad_debounce_encoder #(.N_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(16), .STRICT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .keypad(keypad), .lock(lock), .key_ready(key_ready),
        .key_valid(valid_b), .key_code(code_b), .multi_key(multi_b), .overrun(ovr_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inputs were changed just after an edge; the next edge is E. Valid rises at E+17.
    task automatic expect_press(input string name, input int code);
        step(17);
        chk({name, "_early"}, int'(valid_a), 0);
        step(1);
        chk({name, "_valid"}, int'(valid_a), 1);
        chk({name, "_code"}, int'(code_a), code);
    endtask

    // Scoreboard monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && key_ready) begin
            if (valid_a) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected: got code %0d expected no event at %0t", code_a, $time);
                end else chk("a_sb_code", int'(code_a), qa.pop_front());
            end
            if (valid_b) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got code %0d expected no event at %0t", code_b, $time);
                end else chk("b_sb_code", int'(code_b), qb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int seen;
        int ovr_cnt;

        // Reset values
        step(3);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_code", int'(code_a), 0);
        chk("rst_multi", int'(multi_a), 0);
        chk("rst_overrun", int'(ovr_a), 0);
        rst_n = 1'b1;
        step(3);

        // Single press bit9 -> code 1, one event only while held
        qa.push_back(1); qb.push_back(1);
        keypad = 10'b10_0000_0000;
        expect_press("press9", 1);
        step(1);
        chk("press9_drop", int'(valid_a), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            seen += int'(valid_a);
        end
        chk("press9_norepeat", seen, 0);
        keypad = '0;
        step(25);

        // Bounce on bit4 -> single code 6
        qa.push_back(6); qb.push_back(6);
        for (int i = 0; i < 12; i++) begin
            keypad[4] = ~keypad[4];
            step(5);
        end
        keypad[4] = 1'b1;
        expect_press("bounce", 6);
        step(20);
        keypad = '0;
        step(25);

        // Bits 9 and 0 together: strict drops it, priority gives code 1
        qb.push_back(1);
        keypad = 10'b10_0000_0001;
        step(2);
        chk("multi_lag", int'(multi_a), 0);
        step(1);
        chk("multi_set", int'(multi_a), 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            seen += int'(valid_a);
        end
        chk("multi_strict_noevent", seen, 0);
        keypad = '0;
        step(25);
        chk("multi_clear", int'(multi_a), 0);

        // Overrun: code 3 pending, code 5 dropped
        key_ready = 1'b0;
        qa.push_back(3); qb.push_back(3);
        keypad = 10'b00_1000_0000;
        expect_press("ovr_first", 3);
        step(5);
        keypad = '0;
        step(20);
        keypad = 10'b00_0010_0000;
        ovr_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            ovr_cnt += int'(ovr_a);
        end
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_valid_held", int'(valid_a), 1);
        chk("ovr_code_kept", int'(code_a), 3);
        key_ready = 1'b1;
        step(1);
        chk("ovr_accepted", int'(valid_a), 0);
        keypad = '0;
        step(25);

        // Lock while bit1 is held; no event across unlock
        keypad = 10'b00_0000_0010;
        step(10);
        lock = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            seen += int'(valid_a);
        end
        lock = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            seen += int'(valid_a);
        end
        chk("lock_noevent", seen, 0);
        keypad = '0;
        step(25);
        qa.push_back(9); qb.push_back(9);
        keypad = 10'b00_0000_0010;
        expect_press("after_lock", 9);
        step(5);
        keypad = '0;
        step(25);

        // Lock clears a pending event
        key_ready = 1'b0;
        keypad = 10'b00_0000_0100;
        step(25);
        chk("lockclr_pending", int'(valid_a), 1);
        chk("lockclr_code", int'(code_a), 8);
        lock = 1'b1;
        step(1);
        chk("lockclr_valid", int'(valid_a), 0);
        lock = 1'b0;
        keypad = '0;
        step(25);

        // Async reset with an event pending and a new press mid-debounce
        keypad = 10'b01_0000_0000;
        step(25);
        chk("rst2_pending", int'(valid_a), 1);
        chk("rst2_code", int'(code_a), 2);
        keypad = '0;
        step(20);
        keypad = 10'b00_0100_0000;
        step(8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst2_async_valid", int'(valid_a), 0);
        chk("rst2_async_code", int'(code_a), 0);
        chk("rst2_async_overrun", int'(ovr_a), 0);
        chk("rst2_async_multi", int'(multi_a), 0);
        step(2);
        rst_n = 1'b1;
        qa.push_back(4); qb.push_back(4);
        expect_press("rst2_full_debounce", 4);
        key_ready = 1'b1;
        step(2);
        chk("rst2_accepted", int'(valid_a), 0);
        keypad = '0;
        step(25);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_debounce_encoder.md
# keypad_debounce_encoder

Parametrised, clocked successor to the microwave keypad encoder. It synchronises and debounces a one-hot-per-key keypad bus, resolves simultaneous presses by priority or rejects them, and delivers exactly one key code per physical press. Codes are delivered over a valid/ready handshake to the time-entry logic. Keys are ignored while the oven is running (`lock`).

## Interface
Parameters:
- `N_KEYS`, 10, number of keypad lines, ≥ 2.
- `CODE_W`, 4, key code width, ≥ clog2(N_KEYS).
- `DEBOUNCE_CYCLES`, 16, consecutive identical samples required to accept a press or a release, ≥ 1.
- `STRICT`, 1:
  - 1: two or more lines active counts as "no key" (legacy behaviour).
  - 0: the highest-priority line wins.

Ports (clk and rst_n first):
- `clk`, in, 1, single system clock, rising edge.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `keypad`, in, N_KEYS, raw asynchronous key lines, 1 = pressed.
- `lock`, in, 1, 1 = oven running; keys ignored.
- `key_ready`, in, 1, consumer accepts `key_code` when high together with `key_valid`.
- `key_valid`, out, 1, a debounced key event is pending.
- `key_code`, out, CODE_W, code of the pending event.
- `multi_key`, out, 1, registered flag: more than one synchronised line is active.
- `overrun`, out, 1, one-cycle pulse: a new event was dropped because one was still pending.

## Operation
- Code map: line i maps to code (N_KEYS − i) mod N_KEYS. For N_KEYS=10: bit9→1, bit8→2 … bit1→9, bit0→0.
- Priority (STRICT=0): the highest index wins, so bit0 (code 0) has the lowest priority.
- Synchroniser: a 2-flop stage on `keypad`. The candidate is computed from the second stage.
- Candidate:
  - none if all lines are 0.
  - none if STRICT=1 and more than one line is active.
  - otherwise the prioritised line.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: a candidate present → PRESS_DB. Store the candidate; cnt=1.
  - PRESS_DB, same candidate:
    - cnt<DEBOUNCE_CYCLES-1 → cnt++.
    - cnt=DEBOUNCE_CYCLES-1 → HELD; emit the event.
  - PRESS_DB, different candidate → restart: store the new candidate; cnt=1.
  - PRESS_DB, no candidate → IDLE.
  - HELD: no further events while any line is active, so there is no auto-repeat. All lines 0 → RELEASE_DB; cnt=1.
  - RELEASE_DB: all-zero sample → cnt++, and at cnt=DEBOUNCE_CYCLES-1 → IDLE. Any line active → HELD.
  - DEBOUNCE_CYCLES=1: PRESS_DB and RELEASE_DB each complete on their first sample.
- Event emission:
  - No event pending: `key_valid`←1 and `key_code`←stored code.
  - Event pending: the new event is dropped, `overrun` pulses, and the existing code is kept.
- Handshake:
  - `key_valid` and `key_code` stay stable until the edge where `key_valid`&`key_ready`=1.
  - `key_valid` is 0 after that edge.
  - `key_ready` has no effect while `key_valid`=0.
- Lock: `lock`=1 at an edge does all of the following:
  - clears `key_valid`;
  - forces RELEASE_DB with cnt=0;
  - holds the FSM there while `lock`=1, so a key held across unlock is not reported.
  Release debounce restarts after `lock` falls.
- Counter width: clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it saturates at the transition count.
- Reset values:
  - synchroniser 0;
  - state IDLE, cnt 0;
  - `key_valid` 0, `key_code` 0, `multi_key` 0, `overrun` 0.

## Timing
- Press latency: with `keypad` stable from before edge E, `key_valid` is high after edge E+DEBOUNCE_CYCLES+1.
  - Breakdown: 2 sync edges, 1 edge for IDLE→PRESS_DB, then DEBOUNCE_CYCLES−1 counting edges.
  - With default parameters, `key_valid` is high after edge E+17.
- Release latency: the same count, from lines falling to reaching IDLE.
- `multi_key` lags `keypad` by 3 edges (sync plus a register).
- `overrun` is high for exactly one cycle.
- Simultaneous handshake and new event on the same edge: the handshake completes first, so the new event is accepted with no overrun.
- Simultaneous `lock` and event emission on the same edge: `lock` wins; no event, no overrun.
- Reset asserted mid-debounce or with an event pending: all state clears immediately, with no clock needed.
- Reset release: the first event requires a full press debounce.

## Test plan
- Reset, then press bit9 only, stable, with `key_ready`=1 → `key_valid`=1, `key_code`=1 after exactly 17 edges; then 0 one cycle later; one event only while held.
- Bounce: toggle bit4 every 5 cycles for 60 cycles, then hold → a single `key_code`=6, issued 17 edges after the last toggle.
- STRICT=1 with bits 9 and 0 both high → no event, `multi_key`=1. STRICT=0, same stimulus → `key_code`=1.
- `key_ready`=0; press and release code 3, then press code 5 → `key_valid` held with code 3; `overrun` pulses once; accepting gives code 3.
- `lock`=1 while bit1 is held, then `lock`=0 with bit1 still held → no event. Release, then press bit1 again → `key_code`=9.
- Assert `rst_n`=0 with `key_valid` pending and mid-debounce → all outputs 0 asynchronously; no event after release until a full new debounce.
